// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port, plus the busy scoreboard.
// Optional macro WB_BYPASS_EN: a register committing this cycle is seen as not busy by stall/issue_ready.
module regfile_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*AW-1:0]   req_addr,
    input  logic [N_REQ*XLEN-1:0] req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rf_write_enable,
    output logic [AW-1:0]         rf_write_address,
    output logic [XLEN-1:0]       rf_write_data,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    output logic                  issue_ready,
    input  logic [AW-1:0]         rs1_addr,
    input  logic [AW-1:0]         rs2_addr,
    output logic                  stall,
    output logic [(1<<AW)-1:0]    busy
);
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int NREG = 1 << AW;

    logic [IW-1:0]   r_ptr;
    logic            r_we;
    logic [AW-1:0]   r_waddr;
    logic [XLEN-1:0] r_wdata;
    logic [NREG-1:0] r_busy;

    logic [N_REQ-1:0] w_grant;
    logic             w_found;
    logic [IW-1:0]    w_gidx;
    logic [AW-1:0]    w_sel_addr;
    logic [XLEN-1:0]  w_sel_data;
    int               w_idx;
    logic             w_xfer;
    logic [NREG-1:0]  w_commit;
    logic [NREG-1:0]  w_busy_eff;
    logic [NREG-1:0]  w_busy_nxt;
    logic             w_issue_set;

    // Search starts just after the last granted requester and wraps once around.
    always_comb begin
        w_grant    = '0;
        w_found    = 1'b0;
        w_gidx     = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % N_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found        = 1'b1;
                w_gidx         = w_idx[IW-1:0];
                w_sel_addr     = req_addr[w_idx*AW +: AW];
                w_sel_data     = req_data[w_idx*XLEN +: XLEN];
                w_grant[w_idx] = 1'b1;
            end
        end
        if (reset) begin
            w_grant = '0;
        end
    end

    assign w_xfer    = w_found & ~reset;
    assign req_ready = w_grant;

    always_comb begin
        w_commit = '0;
        if (r_we) begin
            w_commit[r_waddr] = 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    assign w_busy_eff = r_busy & ~w_commit;
`else
    assign w_busy_eff = r_busy;
`endif

    assign issue_ready = (issue_rd == '0) || !w_busy_eff[issue_rd];
    assign stall       = ((rs1_addr != '0) && w_busy_eff[rs1_addr]) ||
                         ((rs2_addr != '0) && w_busy_eff[rs2_addr]);
    assign w_issue_set = issue_valid && issue_ready && (issue_rd != '0);

    // Clear first, then set, so an issue landing on the commit edge keeps the bit.
    always_comb begin
        w_busy_nxt = r_busy & ~w_commit;
        if (w_issue_set) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr   <= IW'(N_REQ - 1);
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_xfer) begin
                r_ptr   <= w_gidx;
                r_we    <= (w_sel_addr != '0);
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign rf_write_enable  = r_we;
    assign rf_write_address = r_waddr;
    assign rf_write_data    = r_wdata;
    assign busy             = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, writeback latency, scoreboard and reset.
// Expectations for the commit-cycle cases follow WB_BYPASS_EN when it is defined.
module tb_regfile_wb_arbiter;
    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        stall;
    logic [31:0] busy;

    int n_cmp = 0;
    int n_err = 0;

`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    regfile_wb_arbiter dut (
        .clock(clk), .reset(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .rf_write_enable(rf_we), .rf_write_address(rf_addr), .rf_write_data(rf_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .stall(stall), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]  = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 3'b111;
        set_req(0, 5'd5, 32'hA);
        set_req(1, 5'd6, 32'hB);
        set_req(2, 5'd7, 32'hC);
        issue_valid = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
        step();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rst_we got %b exp 0", rf_we); end
        n_cmp++; if (rf_addr !== 5'd0) begin n_err++; $display("FAIL rst_addr got %0d exp 0", rf_addr); end
        n_cmp++; if (rf_data !== 32'd0) begin n_err++; $display("FAIL rst_data got %h exp 0", rf_data); end
        n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL rst_busy got %h exp 0", busy); end
        n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL rst_ready got %b exp 000", req_ready); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g;
        for (int k = 0; k < 3; k++) begin
            exp_g = 3'b001 << k;
            #1;
            n_cmp++; if (req_ready !== exp_g) begin n_err++; $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, exp_g); end
            step();
            req_valid[k] = 1'b0;
            n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL rr_we%0d got %b exp 1", k, rf_we); end
            n_cmp++; if (rf_addr !== 5'(5 + k)) begin n_err++; $display("FAIL rr_addr%0d got %0d exp %0d", k, rf_addr, 5 + k); end
            n_cmp++; if (rf_data !== 32'(10 + k)) begin n_err++; $display("FAIL rr_data%0d got %h exp %h", k, rf_data, 10 + k); end
        end
        #1;
        n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL rr_idle_ready got %b exp 000", req_ready); end
        step();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rr_idle_we got %b exp 0", rf_we); end
        n_cmp++; if (rf_addr !== 5'd7 || rf_data !== 32'hC) begin
            n_err++; $display("FAIL rr_hold got %0d/%h exp 7/c", rf_addr, rf_data); end
    endtask

    task automatic test_fairness();
        logic [2:0] vt [0:5];
        logic [2:0] gt [0:5];
        logic [4:0] exp_a;
        vt = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b111, 3'b111};
        gt = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b010};
        set_req(0, 5'd10, 32'h100);
        set_req(1, 5'd12, 32'h101);
        set_req(2, 5'd11, 32'h102);
        for (int k = 0; k < 6; k++) begin
            req_valid = vt[k];
            #1;
            n_cmp++; if (req_ready !== gt[k]) begin n_err++; $display("FAIL fair_grant%0d got %b exp %b", k, req_ready, gt[k]); end
            case (gt[k])
                3'b001:  exp_a = 5'd10;
                3'b010:  exp_a = 5'd12;
                default: exp_a = 5'd11;
            endcase
            step();
            n_cmp++; if (rf_we !== 1'b1 || rf_addr !== exp_a) begin
                n_err++; $display("FAIL fair_wb%0d got %b/%0d exp 1/%0d", k, rf_we, rf_addr, exp_a); end
        end
        req_valid = 3'b000;
        step();
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_rd = 5'd8;
        #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL sb_issue_ok got %b exp 1", issue_ready); end
        step();
        n_cmp++; if (busy !== 32'h100) begin n_err++; $display("FAIL sb_set got %h exp 100", busy); end
        rs1_addr = 5'd8;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL sb_stall_rs1 got %b exp 1", stall); end
        n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL sb_waw got %b exp 0", issue_ready); end
        step();
        issue_valid = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd8;
        n_cmp++; if (busy !== 32'h100) begin n_err++; $display("FAIL sb_waw_hold got %h exp 100", busy); end
        set_req(1, 5'd8, 32'h55);
        req_valid = 3'b010;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL sb_stall_rs2 got %b exp 1", stall); end
        n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL sb_grant got %b exp 010", req_ready); end
        step();
        req_valid = 3'b000;
        #1;
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 5'd8 || rf_data !== 32'h55) begin
            n_err++; $display("FAIL sb_wb got %b/%0d/%h exp 1/8/55", rf_we, rf_addr, rf_data); end
        n_cmp++; if (stall !== !BYP) begin n_err++; $display("FAIL sb_commit_stall got %b exp %b", stall, !BYP); end
        step();
        n_cmp++; if (rf_we !== 1'b0 || busy !== 32'h0 || stall !== 1'b0) begin
            n_err++; $display("FAIL sb_cleared got we=%b busy=%h stall=%b exp 0/0/0", rf_we, busy, stall); end
        rs2_addr = 5'd0;
    endtask

    task automatic test_reg_zero();
        set_req(2, 5'd0, 32'hFFFF_FFFF);
        req_valid = 3'b100;
        #1;
        n_cmp++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL z_grant got %b exp 100", req_ready); end
        step();
        req_valid = 3'b000;
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL z_we got %b exp 0", rf_we); end
        n_cmp++; if (rf_addr !== 5'd0 || rf_data !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL z_load got %0d/%h exp 0/ffffffff", rf_addr, rf_data); end
        issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
        #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL z_issue got %b exp 1", issue_ready); end
        step();
        issue_valid = 1'b0;
        n_cmp++; if (busy !== 32'h0 || stall !== 1'b0) begin
            n_err++; $display("FAIL z_busy got %h/%b exp 0/0", busy, stall); end
    endtask

    task automatic test_reset_mid();
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        n_cmp++; if (busy !== 32'h208) begin n_err++; $display("FAIL rm_busy_pre got %h exp 208", busy); end
        set_req(0, 5'd4, 32'h44);
        set_req(2, 5'd13, 32'h77);
        req_valid = 3'b101;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL rm_grant_pre got %b exp 001", req_ready); end
        step();
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 5'd4) begin
            n_err++; $display("FAIL rm_inflight got %b/%0d exp 1/4", rf_we, rf_addr); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (rf_we !== 1'b0 || busy !== 32'h0 || req_ready !== 3'b000) begin
            n_err++; $display("FAIL rm_async got we=%b busy=%h ready=%b exp 0/0/000", rf_we, busy, req_ready); end
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL rm_first_grant got %b exp 001", req_ready); end
        step();
        req_valid = 3'b000;
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 5'd4 || rf_data !== 32'h44) begin
            n_err++; $display("FAIL rm_post_wb got %b/%0d/%h exp 1/4/44", rf_we, rf_addr, rf_data); end
        step();
    endtask

    task automatic test_bypass();
        issue_valid = 1'b1; issue_rd = 5'd12;
        step();
        issue_valid = 1'b0;
        n_cmp++; if (busy !== 32'h1000) begin n_err++; $display("FAIL bp_set got %h exp 1000", busy); end
        set_req(1, 5'd12, 32'h12);
        req_valid = 3'b010;
        #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL bp_grant got %b exp 010", req_ready); end
        step();
        req_valid = 3'b000;
        issue_valid = 1'b1; issue_rd = 5'd12; rs1_addr = 5'd12;
        #1;
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 5'd12) begin
            n_err++; $display("FAIL bp_commit got %b/%0d exp 1/12", rf_we, rf_addr); end
        n_cmp++; if (issue_ready !== BYP) begin n_err++; $display("FAIL bp_issue got %b exp %b", issue_ready, BYP); end
        n_cmp++; if (stall !== !BYP) begin n_err++; $display("FAIL bp_stall got %b exp %b", stall, !BYP); end
        step();
        issue_valid = 1'b0; rs1_addr = 5'd0;
        n_cmp++; if (busy !== (BYP ? 32'h1000 : 32'h0)) begin
            n_err++; $display("FAIL bp_busy_after got %h exp %h", busy, BYP ? 32'h1000 : 32'h0); end
    endtask

    initial begin
        req_valid = '0; req_addr = '0; req_data = '0;
        test_reset();
        test_round_robin();
        test_fairness();
        test_scoreboard();
        test_reg_zero();
        test_reset_mid();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
